// File: rtl/seg_scan_decoder.sv
// ============================================================================
// seg_scan_decoder: debounces a scanned active-low 7-segment bus and decodes
// each lit digit, committing a 32-bit value once all eight digits are seen.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_scan_decoder #(
  parameter int SETTLE  = 4,      // 2..15
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  SEG,
  input  logic [7:0]  AN,
  output logic [31:0] value,
  output logic [7:0]  dp,
  output logic        err,
  output logic        frame_done,
  output logic        stale
);

  localparam logic [3:0]  SETTLE_C     = 4'(SETTLE);
  localparam logic [3:0]  SETTLE_M1    = 4'(SETTLE - 1);
  localparam logic [15:0] TIMEOUT_C    = 16'(TIMEOUT);

  logic [15:0] prev_q, prev_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] timer_q, timer_d;
  logic [31:0] nib_q, nib_d;
  logic [7:0]  sdp_q, sdp_d;
  logic [7:0]  bad_q, bad_d;
  logic [7:0]  seen_q, seen_d;
  logic [31:0] value_q, value_d;
  logic [7:0]  dp_q, dp_d;
  logic        err_q, err_d;
  logic        frame_done_q, frame_done_d;
  logic        stale_q, stale_d;

  logic [15:0] sample;
  logic        same;
  logic        accept;
  logic [7:0]  an_low;
  logic        one_hot;
  logic [2:0]  idx;
  logic [4:0]  dec;
  logic        digit_acc;
  logic [15:0] timer_inc;

  // Returns {bad, nibble}; unknown patterns decode as nibble 0 with bad set.
  function automatic logic [4:0] decode7(input logic [6:0] p);
    case (p)
      7'h3F: decode7 = 5'h00;
      7'h06: decode7 = 5'h01;
      7'h5B: decode7 = 5'h02;
      7'h4F: decode7 = 5'h03;
      7'h66: decode7 = 5'h04;
      7'h6D: decode7 = 5'h05;
      7'h7D: decode7 = 5'h06;
      7'h07: decode7 = 5'h07;
      7'h7F: decode7 = 5'h08;
      7'h6F: decode7 = 5'h09;
      7'h77: decode7 = 5'h0A;
      7'h7C: decode7 = 5'h0B;
      7'h39: decode7 = 5'h0C;
      7'h5E: decode7 = 5'h0D;
      7'h79: decode7 = 5'h0E;
      7'h71: decode7 = 5'h0F;
      default: decode7 = 5'h10;
    endcase
  endfunction

  always_comb begin
    sample    = {SEG, AN};
    same      = (sample == prev_q);
    accept    = same && (cnt_q == SETTLE_M1);
    an_low    = ~AN;
    one_hot   = (an_low != 8'h00) && ((an_low & (an_low - 8'd1)) == 8'h00);
    idx       = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (an_low[k]) idx = 3'(k);
    end
    dec       = decode7(~SEG[6:0]);
    digit_acc = accept && one_hot;
    timer_inc = timer_q + 16'd1;

    prev_d       = sample;
    cnt_d        = !same ? 4'd0 : ((cnt_q == SETTLE_C) ? cnt_q : cnt_q + 4'd1);
    timer_d      = timer_q;
    nib_d        = nib_q;
    sdp_d        = sdp_q;
    bad_d        = bad_q;
    seen_d       = seen_q;
    value_d      = value_q;
    dp_d         = dp_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    stale_d      = stale_q;

    if (digit_acc) begin
      nib_d[{idx, 2'b00} +: 4] = dec[3:0];
      sdp_d[idx]               = ~SEG[7];
      bad_d[idx]               = dec[4];
      seen_d[idx]              = 1'b1;
      timer_d                  = 16'd0;
      // Commit includes the digit written on this same edge.
      if ((seen_q | an_low) == 8'hFF) begin
        value_d      = nib_d;
        dp_d         = sdp_d;
        err_d        = |bad_d;
        seen_d       = 8'h00;
        bad_d        = 8'h00;
        stale_d      = 1'b0;
        frame_done_d = 1'b1;
      end
    end else if (timer_q != TIMEOUT_C) begin
      timer_d = timer_inc;
      if (timer_inc == TIMEOUT_C) begin
        seen_d  = 8'h00;
        bad_d   = 8'h00;
        stale_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q       <= 16'hFFFF;
      cnt_q        <= 4'd0;
      timer_q      <= 16'd0;
      nib_q        <= 32'd0;
      sdp_q        <= 8'h00;
      bad_q        <= 8'h00;
      seen_q       <= 8'h00;
      value_q      <= 32'd0;
      dp_q         <= 8'h00;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      nib_q        <= nib_d;
      sdp_q        <= sdp_d;
      bad_q        <= bad_d;
      seen_q       <= seen_d;
      value_q      <= value_d;
      dp_q         <= dp_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
      stale_q      <= stale_d;
    end
  end

  assign value      = value_q;
  assign dp         = dp_q;
  assign err        = err_q;
  assign frame_done = frame_done_q;
  assign stale      = stale_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
// ============================================================================
// tb_seg_scan_decoder: directed scans checked every cycle against a
// run-length based model of the display monitor, plus literal expectations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  SEG = 8'hFF;
  logic [7:0]  AN  = 8'hFF;
  logic [31:0] value;
  logic [7:0]  dp;
  logic        err;
  logic        frame_done;
  logic        stale;

  seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .SEG        (SEG),
    .AN         (AN),
    .value      (value),
    .dp         (dp),
    .err        (err),
    .frame_done (frame_done),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int tests  = 0;
  int fails  = 0;
  int fd_cnt = 0;

  // Model state: a digit is taken when the same sample has been seen on
  // exactly SETTLE+1 consecutive edges.
  logic [15:0] m_last;
  int          m_run;
  int          m_idle;
  logic [3:0]  m_dig [8];
  logic [7:0]  m_dpb;
  logic [7:0]  m_bad;
  logic [7:0]  m_seen;
  logic [31:0] m_value;
  logic [7:0]  m_dp;
  logic        m_err;
  logic        m_fd;
  logic        m_stale;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last  = 16'hFFFF;
    m_run   = 1;
    m_idle  = 0;
    for (int j = 0; j < 8; j++) m_dig[j] = 4'd0;
    m_dpb   = 8'h00;
    m_bad   = 8'h00;
    m_seen  = 8'h00;
    m_value = 32'd0;
    m_dp    = 8'h00;
    m_err   = 1'b0;
    m_fd    = 1'b0;
    m_stale = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] s;
    logic [6:0]  pat;
    logic [3:0]  nib;
    logic        bad;
    int          zeros;
    int          idx;
    s = {SEG, AN};
    if (s == m_last) m_run++;
    else begin
      m_run  = 1;
      m_last = s;
    end
    m_fd  = 1'b0;
    zeros = 0;
    idx   = 0;
    for (int i = 0; i < 8; i++) begin
      if (!AN[i]) begin
        zeros++;
        idx = i;
      end
    end
    if (m_run == SETTLE + 1 && zeros == 1) begin
      pat = ~SEG[6:0];
      bad = 1'b1;
      nib = 4'd0;
      for (int k = 0; k < 16; k++) begin
        if (seg_tab[k] == pat) begin
          bad = 1'b0;
          nib = 4'(k);
        end
      end
      m_dig[idx]  = nib;
      m_dpb[idx]  = ~SEG[7];
      m_bad[idx]  = bad;
      m_seen[idx] = 1'b1;
      m_idle      = 0;
      if (m_seen == 8'hFF) begin
        for (int j = 0; j < 8; j++) m_value[4*j +: 4] = m_dig[j];
        m_dp    = m_dpb;
        m_err   = |m_bad;
        m_seen  = 8'h00;
        m_bad   = 8'h00;
        m_stale = 1'b0;
        m_fd    = 1'b1;
      end
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_seen  = 8'h00;
        m_bad   = 8'h00;
        m_stale = 1'b1;
      end
    end
  endtask

  // One clock: advance model on the rising edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    chk("value", value, m_value);
    chk("dp", {24'd0, dp}, {24'd0, m_dp});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
    chk("stale", {31'd0, stale}, {31'd0, m_stale});
    if (frame_done) fd_cnt++;
  endtask

  task automatic show(input int i, input int nib, input bit dpon, input int dwell);
    logic [7:0] one;
    one = 8'h01;
    AN  = ~(one << i);
    SEG = {~dpon, ~seg_tab[nib]};
    repeat (dwell) tick();
  endtask

  task automatic show_raw(input int i, input logic [7:0] seg, input int dwell);
    logic [7:0] one;
    one = 8'h01;
    AN  = ~(one << i);
    SEG = seg;
    repeat (dwell) tick();
  endtask

  task automatic idle(input int n);
    AN  = 8'hFF;
    SEG = 8'hFF;
    repeat (n) tick();
  endtask

  int t3 [8] = '{10, 11, 12, 0, 13, 14, 15, 9};
  int t5 [8] = '{2, 4, 6, 8, 10, 12, 14, 0};

  initial begin
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_value", value, 32'd0);
    chk("rst_dp", {24'd0, dp}, 32'd0);
    chk("rst_flags", {29'd0, err, frame_done, stale}, 32'd0);
    idle(8);

    // Basic frame, 10-cycle dwell.
    fd_cnt = 0;
    for (int i = 0; i < 8; i++) show(i, i + 1, 1'b0, 10);
    chk("t1_value", value, 32'h87654321);
    chk("t1_err", {31'd0, err}, 32'd0);
    chk("t1_fd_count", fd_cnt, 1);

    // Too-short dwell is filtered; long idle times out.
    fd_cnt = 0;
    for (int i = 0; i < 8; i++) show(i, 8 - i, 1'b0, 3);
    chk("t2_fd_count", fd_cnt, 0);
    idle(210);
    chk("t2_stale", {31'd0, stale}, 32'd1);
    chk("t2_value", value, 32'h87654321);

    // Blank digit 3 flags err; next clean frame clears it.
    for (int i = 0; i < 8; i++) begin
      if (i == 3) show_raw(3, 8'hFF, 10);
      else        show(i, t3[i], 1'b0, 10);
    end
    chk("t3_value", value, 32'h9FED0CBA);
    chk("t3_err", {31'd0, err}, 32'd1);
    chk("t3_stale", {31'd0, stale}, 32'd0);
    for (int i = 0; i < 8; i++) show(i, i + 1, 1'b0, 10);
    chk("t3_clean_err", {31'd0, err}, 32'd0);
    chk("t3_clean_value", value, 32'h87654321);

    // Partial frame discarded by timeout.
    fd_cnt = 0;
    for (int i = 0; i < 4; i++) show(i, 5, 1'b0, 10);
    idle(250);
    for (int i = 4; i < 8; i++) show(i, 5, 1'b0, 10);
    chk("t4_stale", {31'd0, stale}, 32'd1);
    chk("t4_fd_count", fd_cnt, 0);
    chk("t4_value", value, 32'h87654321);

    // Decimal points and 1-cycle all-on anode glitches.
    idle(210);
    fd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      show(i, t5[i], (i == 0) || (i == 5), 10);
      if (i < 7) begin
        AN = 8'h00;
        tick();
      end
    end
    chk("t5_value", value, 32'h0ECA8642);
    chk("t5_dp", {24'd0, dp}, 32'h21);
    chk("t5_fd_count", fd_cnt, 1);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 3; i++) show(i, 3, 1'b0, 10);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_async_value", value, 32'd0);
    chk("t6_async_dp", {24'd0, dp}, 32'd0);
    chk("t6_async_flags", {29'd0, err, frame_done, stale}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    fd_cnt = 0;
    for (int i = 0; i < 8; i++) show(i, 2 * i + 1, 1'b0, 10);
    chk("t6_value", value, 32'hFDB97531);
    chk("t6_fd_count", fd_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
